// File: rtl/layer_mux_pkg.sv
// rtl/layer_mux_pkg.sv - shared types, colour key constant and RGB332 expansion
// Contents: rgb332_t / rgb888_t colour types, blink_state_t FSM encoding,
//           DEFAULT_TRANSPARENT colour key, expand_rgb332() helper.
package layer_mux_pkg;

  typedef logic [7:0] rgb332_t;

  typedef struct packed {
    logic [7:0] red;
    logic [7:0] green;
    logic [7:0] blue;
  } rgb888_t;

  typedef enum logic {
    SHOW  = 1'b0,
    BLANK = 1'b1
  } blink_state_t;

  localparam rgb332_t DEFAULT_TRANSPARENT = 8'hFF;

  // Replicating the channel LSB fills the low bits so that full-scale
  // inputs reach 8'hFF and zero stays 8'h00.
  function automatic rgb888_t expand_rgb332(input rgb332_t c);
    rgb888_t e;
    e.red   = {c[7:5], {5{c[5]}}};
    e.green = {c[4:2], {5{c[2]}}};
    e.blue  = {c[1:0], {6{c[0]}}};
    return e;
  endfunction

endpackage

// File: rtl/layer_priority_enc.sv
// rtl/layer_priority_enc.sv - combinational lowest-index-wins priority encoder
// Ports: eligible - one bit per layer, bit 0 has the highest priority
//        found    - at least one eligible bit is set
//        index    - winning layer index, NUM_LAYERS when nothing is eligible
module layer_priority_enc #(
  parameter int NUM_LAYERS = 8
) (
  input  logic [NUM_LAYERS-1:0]           eligible,
  output logic                            found,
  output logic [$clog2(NUM_LAYERS+1)-1:0] index
);

  localparam int IDX_W = $clog2(NUM_LAYERS+1);

  // Scan from the lowest priority upward so the last hit is the winner.
  always_comb begin
    found = 1'b0;
    index = IDX_W'(NUM_LAYERS);
    for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        found = 1'b1;
        index = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/layered_rgb_mux.sv
// rtl/layered_rgb_mux.sv - prioritised layer compositor with blink and RGB332 expansion
// Ports: clk, reset (sync, active-high)
//        layerRGB/layerReq/layerEnable/blinkMask - per-layer colour, request, mask, blink
//        backGroundRGB - colour when no layer wins; pixelValid qualifies inputs
//        startOfFrame  - frame pulse that drives the blink counter
//        redOut/greenOut/blueOut/topLayer/outValid - results, 2 cycles after inputs
module layered_rgb_mux
  import layer_mux_pkg::*;
#(
  parameter int      NUM_LAYERS   = 8,
  parameter rgb332_t TRANSPARENT  = DEFAULT_TRANSPARENT,
  parameter int      BLINK_FRAMES = 16
) (
  input  logic                            clk,
  input  logic                            reset,
  input  rgb332_t [NUM_LAYERS-1:0]        layerRGB,
  input  logic [NUM_LAYERS-1:0]           layerReq,
  input  logic [NUM_LAYERS-1:0]           layerEnable,
  input  logic [NUM_LAYERS-1:0]           blinkMask,
  input  rgb332_t                         backGroundRGB,
  input  logic                            pixelValid,
  input  logic                            startOfFrame,
  output logic [7:0]                      redOut,
  output logic [7:0]                      greenOut,
  output logic [7:0]                      blueOut,
  output logic                            outValid,
  output logic [$clog2(NUM_LAYERS+1)-1:0] topLayer
);

  localparam int               IDX_W      = $clog2(NUM_LAYERS+1);
  localparam logic [IDX_W-1:0] BG_IDX     = IDX_W'(NUM_LAYERS);
  localparam logic [7:0]       FRAME_LAST = 8'(BLINK_FRAMES - 1);

  blink_state_t     blink_state;
  logic [7:0]       frameCnt;
  logic             blinkPhase;
  logic [NUM_LAYERS-1:0] eligible;
  logic             found;
  logic [IDX_W-1:0] win_idx;
  rgb332_t          sel_rgb;
  rgb888_t          s1_exp;

  rgb332_t          s1_rgb;
  logic [IDX_W-1:0] s1_idx;
  logic             s1_vld;

  // Blink counter and FSM. The phase is registered, so a pulse only
  // affects pixels sampled from the following cycle on.
  always_ff @(posedge clk) begin
    if (reset) begin
      blink_state <= SHOW;
      frameCnt    <= 8'd0;
    end else if (startOfFrame) begin
      if (frameCnt == FRAME_LAST) begin
        frameCnt <= 8'd0;
        case (blink_state)
          SHOW:    blink_state <= BLANK;
          BLANK:   blink_state <= SHOW;
          default: blink_state <= SHOW;
        endcase
      end else begin
        frameCnt <= frameCnt + 8'd1;
      end
    end
  end

  assign blinkPhase = (blink_state == BLANK);

  always_comb begin
    eligible = '0;
    for (int i = 0; i < NUM_LAYERS; i++) begin
      eligible[i] = layerReq[i] && layerEnable[i] &&
                    (layerRGB[i] != TRANSPARENT) &&
                    !(blinkMask[i] && blinkPhase);
    end
  end

  layer_priority_enc #(
    .NUM_LAYERS (NUM_LAYERS)
  ) u_prio (
    .eligible (eligible),
    .found    (found),
    .index    (win_idx)
  );

  // Background passes through unfiltered, even if it matches the colour key.
  always_comb begin
    sel_rgb = backGroundRGB;
    for (int i = 0; i < NUM_LAYERS; i++) begin
      if (found && (win_idx == IDX_W'(i))) begin
        sel_rgb = layerRGB[i];
      end
    end
  end

  // Stage 1: selection. Invalid cycles load a neutral pixel so the
  // outputs read as black/background while outValid is low.
  always_ff @(posedge clk) begin
    if (reset || !pixelValid) begin
      s1_rgb <= 8'h00;
      s1_idx <= BG_IDX;
      s1_vld <= 1'b0;
    end else begin
      s1_rgb <= sel_rgb;
      s1_idx <= win_idx;
      s1_vld <= 1'b1;
    end
  end

  assign s1_exp = expand_rgb332(s1_rgb);

  // Stage 2: colour expansion.
  always_ff @(posedge clk) begin
    if (reset) begin
      redOut   <= 8'h00;
      greenOut <= 8'h00;
      blueOut  <= 8'h00;
      topLayer <= BG_IDX;
      outValid <= 1'b0;
    end else begin
      redOut   <= s1_exp.red;
      greenOut <= s1_exp.green;
      blueOut  <= s1_exp.blue;
      topLayer <= s1_idx;
      outValid <= s1_vld;
    end
  end

endmodule
